// File: rtl/imm_pkg.sv
// Shared types and helpers for the immediate generator stage.
// Selector encoding and the XLEN-dependent shift-amount width.
package imm_pkg;

    typedef enum logic [2:0] {
        SEL_I     = 3'd0,
        SEL_S     = 3'd1,
        SEL_B     = 3'd2,
        SEL_U     = 3'd3,
        SEL_J     = 3'd4,
        SEL_SHAMT = 3'd5,
        SEL_ZIMM  = 3'd6
    } imm_sel_t;

    function automatic int shamt_width(input int xlen);
        return (xlen == 64) ? 6 : 5;
    endfunction

endpackage

// File: rtl/imm_decode.sv
// Combinational immediate decoder for RV32/RV64 instruction words.
// Undefined selector codes yield a zero immediate and raise illegal.
module imm_decode #(
    parameter int XLEN = 64
) (
    input  logic [31:0]     instr,
    input  logic [2:0]      sel,
    output logic [XLEN-1:0] imm,
    output logic            illegal
);
    import imm_pkg::*;

    localparam int SW = shamt_width(XLEN);

    logic s;
    logic unused_bits;

    assign s = instr[31];
    assign unused_bits = ^instr[6:0];

    always_comb begin
        imm = '0;
        illegal = 1'b0;
        case (sel)
            SEL_I:
                imm = {{(XLEN-12){s}}, instr[31:20]};
            SEL_S:
                imm = {{(XLEN-12){s}}, instr[31:25], instr[11:7]};
            SEL_B:
                imm = {{(XLEN-13){s}}, instr[31], instr[7],
                       instr[30:25], instr[11:8], 1'b0};
            // Signed cast keeps this legal when XLEN leaves no upper bits
            SEL_U:
                imm = XLEN'($signed({instr[31:12], 12'b0}));
            SEL_J:
                imm = {{(XLEN-21){s}}, instr[31], instr[19:12],
                       instr[20], instr[30:21], 1'b0};
            SEL_SHAMT:
                imm = XLEN'(instr[20 +: SW]);
            SEL_ZIMM:
                imm = XLEN'(instr[19:15]);
            default:
                illegal = 1'b1;
        endcase
    end

endmodule

// File: rtl/imm_gen_stage.sv
// Pipelined immediate generator: decode, PC-relative target, and a
// two-entry skid buffer behind a valid/ready handshake.
module imm_gen_stage #(
    parameter int XLEN  = 64,
    parameter int TAG_W = 8
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [31:0]      in_instr,
    input  logic [2:0]       in_sel,
    input  logic [XLEN-1:0]  in_pc,
    input  logic [TAG_W-1:0] in_tag,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [XLEN-1:0]  out_imm,
    output logic [XLEN-1:0]  out_target,
    output logic             out_illegal,
    output logic [TAG_W-1:0] out_tag
);
    import imm_pkg::*;

    if (XLEN != 32 && XLEN != 64) begin : g_bad_xlen
        $error("imm_gen_stage: XLEN must be 32 or 64");
    end

    localparam logic [1:0] ST_EMPTY = 2'b00;
    localparam logic [1:0] ST_ONE   = 2'b01;
    localparam logic [1:0] ST_FULL  = 2'b11;

    logic [XLEN-1:0]  dec_imm;
    logic             dec_illegal;
    logic [XLEN-1:0]  new_target;
    logic             accept;
    logic [1:0]       state;

    logic             skid_valid;
    logic [XLEN-1:0]  skid_imm;
    logic [XLEN-1:0]  skid_target;
    logic             skid_illegal;
    logic [TAG_W-1:0] skid_tag;

    imm_decode #(
        .XLEN(XLEN)
    ) u_decode (
        .instr   (in_instr),
        .sel     (in_sel),
        .imm     (dec_imm),
        .illegal (dec_illegal)
    );

    assign new_target = in_pc + dec_imm;
    assign accept     = in_valid && in_ready;
    assign state      = {skid_valid, out_valid};

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            out_valid    <= 1'b0;
            out_imm      <= '0;
            out_target   <= '0;
            out_illegal  <= 1'b0;
            out_tag      <= '0;
            skid_valid   <= 1'b0;
            skid_imm     <= '0;
            skid_target  <= '0;
            skid_illegal <= 1'b0;
            skid_tag     <= '0;
            in_ready     <= 1'b1;
        end else begin
            case (state)
                ST_EMPTY: begin
                    if (accept) begin
                        out_valid   <= 1'b1;
                        out_imm     <= dec_imm;
                        out_target  <= new_target;
                        out_illegal <= dec_illegal;
                        out_tag     <= in_tag;
                    end
                end
                ST_ONE: begin
                    if (accept && !out_ready) begin
                        skid_valid   <= 1'b1;
                        skid_imm     <= dec_imm;
                        skid_target  <= new_target;
                        skid_illegal <= dec_illegal;
                        skid_tag     <= in_tag;
                        in_ready     <= 1'b0;
                    end else if (accept) begin
                        out_imm     <= dec_imm;
                        out_target  <= new_target;
                        out_illegal <= dec_illegal;
                        out_tag     <= in_tag;
                    end else if (out_ready) begin
                        out_valid <= 1'b0;
                    end
                end
                // in_ready is low here, so no accept can coincide
                ST_FULL: begin
                    if (out_ready) begin
                        out_imm     <= skid_imm;
                        out_target  <= skid_target;
                        out_illegal <= skid_illegal;
                        out_tag     <= skid_tag;
                        skid_valid  <= 1'b0;
                        in_ready    <= 1'b1;
                    end
                end
                default: ;
            endcase
        end
    end

    a_stall_stable: assert property (
        @(posedge clk) disable iff (reset)
        (out_valid && !out_ready) |=>
        (out_valid && $stable(out_imm) && $stable(out_target)
         && $stable(out_illegal) && $stable(out_tag))
    );

endmodule

// File: tb/tb_imm_gen_stage.sv
// Directed bench for imm_gen_stage at XLEN=64 and XLEN=32.
// Vector table for decode/target, hand sequences for buffering and reset.
module tb_imm_gen_stage;

    logic        clk;
    logic        reset;

    logic        v64, r64, ov64, or64, il64;
    logic [31:0] ins64;
    logic [2:0]  sel64;
    logic [63:0] pc64, imm64, tgt64;
    logic [7:0]  tag64, otag64;

    logic        v32, r32, ov32, or32, il32;
    logic [31:0] ins32;
    logic [2:0]  sel32;
    logic [31:0] pc32, imm32, tgt32;
    logic [7:0]  tag32, otag32;

    int checks = 0;
    int failures = 0;

    imm_gen_stage #(.XLEN(64), .TAG_W(8)) dut64 (
        .clk(clk), .reset(reset),
        .in_valid(v64), .in_ready(r64),
        .in_instr(ins64), .in_sel(sel64), .in_pc(pc64), .in_tag(tag64),
        .out_valid(ov64), .out_ready(or64),
        .out_imm(imm64), .out_target(tgt64),
        .out_illegal(il64), .out_tag(otag64)
    );

    imm_gen_stage #(.XLEN(32), .TAG_W(8)) dut32 (
        .clk(clk), .reset(reset),
        .in_valid(v32), .in_ready(r32),
        .in_instr(ins32), .in_sel(sel32), .in_pc(pc32), .in_tag(tag32),
        .out_valid(ov32), .out_ready(or32),
        .out_imm(imm32), .out_target(tgt32),
        .out_illegal(il32), .out_tag(otag32)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [63:0] act,
                       input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    typedef struct {
        bit          w32;
        logic [31:0] instr;
        logic [2:0]  sel;
        logic [63:0] pc;
        logic [63:0] imm;
        logic [63:0] tgt;
        logic        ill;
    } vec_t;

    localparam int NV = 16;
    vec_t tv[NV];

    int  cyc;
    int  sent;
    int  got_n;
    logic [7:0] got_tag[8];
    int  got_cyc[8];
    bit  acc;
    bit  stale;

    initial begin
        tv[0]  = '{0, 32'hFFF00093, 3'd0, 64'h1000,
                   64'hFFFF_FFFF_FFFF_FFFF, 64'h0FFF, 1'b0};
        tv[1]  = '{0, 32'hFE112E23, 3'd1, 64'h100,
                   64'hFFFF_FFFF_FFFF_FFFC, 64'hFC, 1'b0};
        tv[2]  = '{0, 32'h800002B7, 3'd3, 64'h1000,
                   64'hFFFF_FFFF_8000_0000, 64'hFFFF_FFFF_8000_1000, 1'b0};
        tv[3]  = '{0, 32'h12345037, 3'd3, 64'h0,
                   64'h1234_5000, 64'h1234_5000, 1'b0};
        tv[4]  = '{0, 32'h0080006F, 3'd4, 64'h1000,
                   64'h8, 64'h1008, 1'b0};
        tv[5]  = '{0, 32'hFFDFF06F, 3'd4, 64'h2000,
                   64'hFFFF_FFFF_FFFF_FFFC, 64'h1FFC, 1'b0};
        tv[6]  = '{0, 32'h02000013, 3'd5, 64'h0,
                   64'd32, 64'd32, 1'b0};
        tv[7]  = '{0, 32'h000F8073, 3'd6, 64'h10,
                   64'd31, 64'h2F, 1'b0};
        tv[8]  = '{0, 32'hFFFFFFFF, 3'd7, 64'h2000,
                   64'h0, 64'h2000, 1'b1};
        tv[9]  = '{0, 32'h80000063, 3'd2, 64'h10,
                   64'hFFFF_FFFF_FFFF_F000, 64'hFFFF_FFFF_FFFF_F010, 1'b0};
        tv[10] = '{1, 32'h80000063, 3'd2, 64'h10,
                   64'hFFFF_F000, 64'hFFFF_F010, 1'b0};
        tv[11] = '{1, 32'h02000013, 3'd5, 64'h40,
                   64'h0, 64'h40, 1'b0};
        tv[12] = '{1, 32'h01F00013, 3'd5, 64'h0,
                   64'd31, 64'd31, 1'b0};
        tv[13] = '{1, 32'hFFF00093, 3'd0, 64'h0,
                   64'hFFFF_FFFF, 64'hFFFF_FFFF, 1'b0};
        tv[14] = '{1, 32'hABCDEF01, 3'd7, 64'h123,
                   64'h0, 64'h123, 1'b1};
        tv[15] = '{1, 32'h800002B7, 3'd3, 64'h8000_0000,
                   64'h8000_0000, 64'h0, 1'b0};

        v64 = 0; ins64 = '0; sel64 = '0; pc64 = '0; tag64 = '0; or64 = 1;
        v32 = 0; ins32 = '0; sel32 = '0; pc32 = '0; tag32 = '0; or32 = 1;

        reset = 1'b1;
        #1;
        chk("rst_out_valid", 64'(ov64), 64'd0);
        chk("rst_in_ready", 64'(r64), 64'd1);
        chk("rst_imm", imm64, 64'd0);
        chk("rst_target", tgt64, 64'd0);
        chk("rst_illegal", 64'(il64), 64'd0);
        chk("rst_tag", 64'(otag64), 64'd0);
        chk("rst32_valid", 64'(ov32), 64'd0);
        chk("rst32_ready", 64'(r32), 64'd1);
        @(posedge clk); #1;
        reset = 1'b0;
        @(posedge clk); #1;

        for (int i = 0; i < NV; i++) begin
            if (!tv[i].w32) begin
                v64 = 1; ins64 = tv[i].instr; sel64 = tv[i].sel;
                pc64 = tv[i].pc; tag64 = 8'(i);
            end else begin
                v32 = 1; ins32 = tv[i].instr; sel32 = tv[i].sel;
                pc32 = tv[i].pc[31:0]; tag32 = 8'(i);
            end
            @(posedge clk); #1;
            v64 = 0; v32 = 0;
            if (!tv[i].w32) begin
                chk($sformatf("v%0d_valid", i), 64'(ov64), 64'd1);
                chk($sformatf("v%0d_imm", i), imm64, tv[i].imm);
                chk($sformatf("v%0d_target", i), tgt64, tv[i].tgt);
                chk($sformatf("v%0d_illegal", i), 64'(il64), 64'(tv[i].ill));
                chk($sformatf("v%0d_tag", i), 64'(otag64), 64'(i));
                chk($sformatf("v%0d_ready", i), 64'(r64), 64'd1);
            end else begin
                chk($sformatf("v%0d_valid", i), 64'(ov32), 64'd1);
                chk($sformatf("v%0d_imm", i), 64'(imm32), tv[i].imm);
                chk($sformatf("v%0d_target", i), 64'(tgt32), tv[i].tgt);
                chk($sformatf("v%0d_illegal", i), 64'(il32), 64'(tv[i].ill));
                chk($sformatf("v%0d_tag", i), 64'(otag32), 64'(i));
            end
        end

        @(posedge clk); #1;
        chk("drain_empty", 64'(ov64), 64'd0);

        // back-pressure: tags 1..4, out_ready low for cycles 0..2
        sent = 0; got_n = 0;
        ins64 = 32'h00100093; sel64 = 3'd0; pc64 = 64'h0;
        for (cyc = 0; cyc < 20 && got_n < 4; cyc++) begin
            or64 = (cyc >= 3);
            v64 = (sent < 4);
            tag64 = 8'(sent + 1);
            if (cyc == 2) begin
                chk("bp_in_ready_low", 64'(r64), 64'd0);
                chk("bp_stall_tag", 64'(otag64), 64'd1);
                chk("bp_stall_valid", 64'(ov64), 64'd1);
            end
            acc = v64 && r64;
            if (ov64 && or64 && got_n < 8) begin
                got_tag[got_n] = otag64;
                got_cyc[got_n] = cyc;
                got_n++;
            end
            @(posedge clk); #1;
            if (acc) sent++;
        end
        v64 = 0;
        chk("bp_got_count", 64'(got_n), 64'd4);
        for (int k = 0; k < 4; k++) begin
            chk($sformatf("bp_tag%0d", k), 64'(got_tag[k]), 64'(k + 1));
            chk($sformatf("bp_cyc%0d", k), 64'(got_cyc[k]), 64'(k + 3));
        end
        @(posedge clk); #1;
        chk("bp_empty", 64'(ov64), 64'd0);

        // reset while FULL
        or64 = 0;
        v64 = 1; tag64 = 8'd9;
        @(posedge clk); #1;
        tag64 = 8'd10;
        @(posedge clk); #1;
        v64 = 0;
        chk("full_ready_low", 64'(r64), 64'd0);
        #2 reset = 1'b1;
        #1;
        chk("arst_valid", 64'(ov64), 64'd0);
        chk("arst_ready", 64'(r64), 64'd1);
        chk("arst_imm", imm64, 64'd0);
        @(posedge clk); #1;
        reset = 1'b0;
        or64 = 1;
        stale = 0;
        for (int k = 0; k < 4; k++) begin
            @(posedge clk); #1;
            if (ov64) stale = 1;
        end
        chk("no_stale_beat", 64'(stale), 64'd0);
        v64 = 1; tag64 = 8'd11; ins64 = 32'hFFF00093; pc64 = 64'h1000;
        @(posedge clk); #1;
        v64 = 0;
        chk("post_rst_valid", 64'(ov64), 64'd1);
        chk("post_rst_tag", 64'(otag64), 64'd11);
        chk("post_rst_target", tgt64, 64'h0FFF);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/imm_gen_stage.md
# imm_gen_stage

Pipelined, parametrised immediate generator with a valid/ready handshake.
- Decodes the immediate from a 32-bit RISC-V instruction for XLEN 32 or 64.
- Computes the PC-relative target and registers both results behind a two-entry skid buffer.
- Sits between instruction fetch/decode and the execute stage; replaces the flat combinational immediate mux.
- Adds back-pressure, an illegal-selector flag and target arithmetic.

## Interface
Parameters:
- XLEN, 64, datapath width; legal values 32 and 64 only (elaboration error otherwise)
- TAG_W, 8, width of the opaque sideband tag carried alongside each instruction

Ports:
- clk  in  1  clock
- reset  in  1  asynchronous, active-high reset
- in_valid  in  1  upstream beat valid
- in_ready  out  1  stage can accept a beat
- in_instr  in  32  raw instruction word
- in_sel  in  3  immediate format selector (imm_pkg::imm_sel_t)
- in_pc  in  XLEN  PC of the instruction
- in_tag  in  TAG_W  sideband, passed through unchanged
- out_valid  out  1  result beat valid
- out_ready  in  1  downstream accepts the beat
- out_imm  out  XLEN  decoded immediate
- out_target  out  XLEN  in_pc + out_imm, modulo 2^XLEN
- out_illegal  out  1  selector was not a defined format
- out_tag  out  TAG_W  tag of the beat

## Operation
Immediate formats, from instruction bits i[31:0], sign s = i[31]:
- I: sext(i[31:20])
- S: sext({i[31:25], i[11:7]})
- B: sext({i[31], i[7], i[30:25], i[11:8], 1'b0})
- U: sext({i[31:12], 12'b0}); upper bits copy i[31] when XLEN=64
- J: sext({i[31], i[19:12], i[20], i[30:21], 1'b0})
- SHAMT: zero-extended i[24:20] for XLEN=32, i[25:20] for XLEN=64
- ZIMM: zero-extended i[19:15]

Illegal selector handling:
- Any undefined selector code gives out_imm = 0, out_target = in_pc and out_illegal = 1.
- The beat still flows through the stage; it is never dropped and never X.

Target computation:
- out_target is the full-width wrapping sum of in_pc and the decoded immediate, for every format including SHAMT/ZIMM.
- Consumers ignore the target where it is meaningless.

Buffering:
- One main output register plus one skid register.
- Accept condition: in_valid && in_ready.
- in_ready = !skid_valid, driven directly from a flop.
- Buffer states:
  - EMPTY: main and skid both invalid.
  - ONE: main valid, skid invalid.
  - FULL: main and skid both valid.
- Transitions:
  - EMPTY + accept -> ONE.
  - ONE + accept + !out_ready -> FULL; the new beat goes to skid.
  - ONE + accept + out_ready -> ONE; main is replaced.
  - ONE + !accept + out_ready -> EMPTY.
  - FULL + out_ready -> ONE; skid moves to main.
- Ordering is strictly FIFO; no beat is lost or duplicated.

## Timing
- Latency is one cycle: a beat accepted at edge N appears on out_* after edge N.
- Full throughput is one beat per cycle while out_ready stays high.
- out_* stay stable while out_valid && !out_ready; this is a required assertion.
- in_ready falls in the cycle after a stall begins with one beat outstanding. It rises in the cycle after skid drains.
- Reset values on assertion of reset, asynchronously:
  - out_valid = 0, skid_valid = 0, in_ready = 1.
  - out_imm, out_target, out_tag = 0; out_illegal = 0.
- Reset mid-stream discards all buffered beats. The first accept after release is at the first rising edge with reset low.
- Simultaneous accept and drain in FULL is impossible because in_ready = 0.

## Structure
- Package imm_pkg holds:
  - imm_sel_t enum, 3 bits: I=0, S=1, B=2, U=3, J=4, SHAMT=5, ZIMM=6; 7 is undefined.
  - A function returning the SHAMT width for a given XLEN.
- Sub-module imm_decode is purely combinational: instr, sel -> imm, illegal, parametrised by XLEN.
- imm_gen_stage instantiates imm_decode, the adder and the skid buffer.

## Test plan
- I-format, XLEN=64, instr 32'hFFF00093, pc 64'h1000, out_ready=1:
  - out_imm = 64'hFFFF_FFFF_FFFF_FFFF and out_target = 64'h0FFF, one cycle later.
- B-format, instr 32'h80000063, XLEN=32, pc 32'h0000_0010:
  - out_imm = 32'hFFFF_F000 and out_target = 32'hFFFF_F010.
- Back-pressure with beats tagged 1..4 back-to-back:
  - out_ready held low 3 cycles gives in_ready = 0 after two accepts.
  - Release gives tags 1,2,3,4 in order, with no gaps once in_ready recovers.
- Selector 7 with any instr, pc 64'h2000:
  - out_illegal = 1, out_imm = 0, out_target = 64'h2000.
- SHAMT with instr bit 25 set:
  - out_imm = 32 at XLEN=64.
  - out_imm = 0 at XLEN=32, since i[25] is ignored.
- Reset asserted while FULL:
  - Asynchronously out_valid = 0, in_ready = 1, out_imm = 0.
  - No stale beat emerges after release.
